// File: rtl/wl_clkgate_mgr.sv
// Per-channel idle-based clock gate manager: RUN/COUNT/GATED/WAKE FSM per channel.
// Optional macro WL_CLKGATE_STAT_EN adds per-channel saturating gated-cycle counters.
module wl_clkgate_mgr #(
   parameter int CLK_NUM  = 4,
   parameter int CNT_W    = 8,
   parameter int WAKE_DLY = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 dft_se,
   input  logic [CLK_NUM-1:0]   busy_i,
   input  logic [CLK_NUM-1:0]   force_on_i,
   input  logic [CNT_W-1:0]     idle_thr_i,
   output logic [CLK_NUM-1:0]   gate_en_o,
   output logic [CLK_NUM-1:0]   ready_o,
   output logic [CLK_NUM-1:0]   wake_done_o,
   output logic [CLK_NUM-1:0]   gated_o
`ifdef WL_CLKGATE_STAT_EN
   ,
   output logic [CLK_NUM*16-1:0] gated_cnt_o
`endif
);

   // The counter also times WAKE, so it must be wide enough for WAKE_DLY up to 255.
   localparam int CW = (CNT_W > 8) ? CNT_W : 8;
   localparam logic [CW-1:0] WAKE_LAST = (WAKE_DLY > 0) ? CW'(WAKE_DLY - 1) : '0;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      COUNT = 2'd1,
      GATED = 2'd2,
      WAKE  = 2'd3
   } state_e;

   state_e             state_q [CLK_NUM];
   state_e             state_d [CLK_NUM];
   logic [CW-1:0]      cnt_q   [CLK_NUM];
   logic [CW-1:0]      cnt_d   [CLK_NUM];
   logic [CLK_NUM-1:0] wake_q;
   logic [CLK_NUM-1:0] wake_d;
   logic [CLK_NUM-1:0] act;
   logic [CLK_NUM-1:0] en;
   logic [CW-1:0]      thrExt;
   logic [CW-1:0]      thrLast;
   logic               thrZero;

   assign act     = busy_i | force_on_i;
   assign thrExt  = CW'(idle_thr_i);
   assign thrLast = thrExt - CW'(1);
   assign thrZero = (idle_thr_i == '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < CLK_NUM; i++) begin
            state_q[i] <= RUN;
            cnt_q[i]   <= '0;
         end
         wake_q <= '0;
      end else begin
         for (int i = 0; i < CLK_NUM; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         wake_q <= wake_d;
      end
   end

   // A threshold lowered below the running count gates on the very next edge.
   always_comb begin
      for (int i = 0; i < CLK_NUM; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         wake_d[i]  = 1'b0;
         case (state_q[i])
            RUN: begin
               if (!act[i] && !thrZero) begin
                  state_d[i] = COUNT;
                  cnt_d[i]   = '0;
               end
            end
            COUNT: begin
               if (act[i] || thrZero) begin
                  state_d[i] = RUN;
               end else if (cnt_q[i] >= thrLast) begin
                  state_d[i] = GATED;
               end else begin
                  cnt_d[i] = cnt_q[i] + CW'(1);
               end
            end
            GATED: begin
               if (act[i]) begin
                  if (WAKE_DLY == 0) begin
                     state_d[i] = RUN;
                     wake_d[i]  = 1'b1;
                  end else begin
                     state_d[i] = WAKE;
                     cnt_d[i]   = '0;
                  end
               end
            end
            WAKE: begin
               if (cnt_q[i] >= WAKE_LAST) begin
                  state_d[i] = RUN;
                  wake_d[i]  = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CW'(1);
               end
            end
            default: begin
               state_d[i] = RUN;
            end
         endcase
      end
   end

   always_comb begin
      en      = '0;
      ready_o = '0;
      gated_o = '0;
      for (int i = 0; i < CLK_NUM; i++) begin
         en[i]      = (state_q[i] != GATED);
         ready_o[i] = (state_q[i] == RUN) || (state_q[i] == COUNT);
         gated_o[i] = (state_q[i] == GATED);
      end
   end

   // Scan enable bypasses the FSM combinationally so test clocks run immediately.
   assign gate_en_o   = en | {CLK_NUM{dft_se}};
   assign wake_done_o = wake_q;

`ifdef WL_CLKGATE_STAT_EN
   logic [15:0] gcnt_q [CLK_NUM];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < CLK_NUM; i++) begin
            gcnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CLK_NUM; i++) begin
            if ((state_q[i] == GATED) && (gcnt_q[i] != 16'hFFFF)) begin
               gcnt_q[i] <= gcnt_q[i] + 16'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < CLK_NUM; g++) begin : g_stat
      assign gated_cnt_o[g*16 +: 16] = gcnt_q[g];
   end
`endif

endmodule
